// File: rtl/csync_adaptive.sv
// Composite/horizontal sync generator driven only by TIA vsync, with frame-length measurement and phase lock.
// Define CSYNC_EQ_PULSES_EN to emit equalising lines around vsync; otherwise those lines are normal.
module csync_adaptive #(
    parameter int LINE_CLKS        = 766,
    parameter int HSYNC_CLKS       = 56,
    parameter int SERR_CLKS        = 56,
    parameter int EQ_CLKS          = 28,
    parameter int EQ_LINES         = 3,
    parameter int LINE_W           = 9,
    parameter int LOCK_TOL         = 4,
    parameter int LOCK_FRAMES      = 3,
    parameter int VSYNC_ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vsync,
    output logic              csync,
    output logic              hsync,
    output logic [1:0]        line_type,
    output logic [LINE_W-1:0] line_cnt,
    output logic [LINE_W-1:0] frame_lines,
    output logic              locked
);

    // line type | meaning
    // LT_NORMAL | one hsync-width pulse at line start
    // LT_BROAD  | vsync line: low except two serration gaps
    // LT_EQ     | two short pulses, at line start and half line
    typedef enum logic [1:0] {LT_NORMAL = 2'd0, LT_BROAD = 2'd1, LT_EQ = 2'd2} line_type_t;

    localparam int H_W  = $clog2(LINE_CLKS);
    localparam int HALF = LINE_CLKS / 2;
    localparam int LK_W = $clog2(LOCK_FRAMES + 1);
    localparam int PW   = $clog2(EQ_LINES + 1);
    localparam logic [LINE_W-1:0] LINE_MAX = '1;
`ifdef CSYNC_EQ_PULSES_EN
    localparam bit EQ_EN = 1'b1;
`else
    localparam bit EQ_EN = 1'b0;
`endif

    logic [H_W-1:0]    r_h_cnt;
    logic [LK_W-1:0]   r_lock_cnt;
    logic [PW-1:0]     r_post_cnt;
    logic              r_vs_q;

    logic              w_vs_act;
    logic              w_edge;
    logic              w_wrap;
    logic              w_in_phase;
    logic              w_pre_eq;
    logic              w_eq_win;
    logic              w_hs_low;
    logic              w_cs_low;
    logic [LINE_W-1:0] w_line_nxt;
    logic [LINE_W-1:0] w_frame_meas;
    logic [LK_W-1:0]   w_lock_nxt;

    assign w_vs_act     = vsync ^ (VSYNC_ACTIVE_LOW != 0);
    assign w_edge       = w_vs_act & ~r_vs_q;
    assign w_wrap       = (r_h_cnt == H_W'(LINE_CLKS - 1));
    assign w_line_nxt   = (line_cnt == LINE_MAX) ? line_cnt : line_cnt + 1'b1;
    // A frame ending past mid-line rounds up to the next whole line.
    assign w_frame_meas = (r_h_cnt >= H_W'(HALF)) ? w_line_nxt : line_cnt;
    assign w_in_phase   = (r_h_cnt <= H_W'(LOCK_TOL)) || (r_h_cnt >= H_W'(LINE_CLKS - LOCK_TOL));
    assign w_lock_nxt   = !w_in_phase ? '0 :
                          (r_lock_cnt == LK_W'(LOCK_FRAMES)) ? r_lock_cnt : r_lock_cnt + 1'b1;

    // Prediction of the next vsync only trusted once the frame length is locked.
    assign w_pre_eq = locked &
                      (({1'b0, w_line_nxt} + (LINE_W+1)'(EQ_LINES)) >= {1'b0, frame_lines});
    assign w_eq_win = EQ_EN & ~w_vs_act & (w_pre_eq | (r_post_cnt != '0));

    always_comb begin
        w_hs_low = (r_h_cnt < H_W'(HSYNC_CLKS));
        w_cs_low = w_hs_low;
        case (line_type)
            LT_BROAD: w_cs_low = !(((r_h_cnt >= H_W'(HALF - SERR_CLKS)) && (r_h_cnt < H_W'(HALF))) ||
                                   (r_h_cnt >= H_W'(LINE_CLKS - SERR_CLKS)));
            LT_EQ:    w_cs_low = (r_h_cnt < H_W'(EQ_CLKS)) ||
                                 ((r_h_cnt >= H_W'(HALF)) && (r_h_cnt < H_W'(HALF + EQ_CLKS)));
            default:  w_cs_low = w_hs_low;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_h_cnt     <= '0;
            r_lock_cnt  <= '0;
            r_post_cnt  <= '0;
            r_vs_q      <= 1'b0;
            line_cnt    <= '0;
            frame_lines <= '0;
            line_type   <= LT_NORMAL;
            locked      <= 1'b0;
            csync       <= 1'b1;
            hsync       <= 1'b1;
        end else begin
            r_vs_q <= w_vs_act;
            csync  <= ~w_cs_low;
            hsync  <= ~w_hs_low;

            if (w_vs_act)
                r_post_cnt <= PW'(EQ_LINES);
            else if (w_wrap && (r_post_cnt != '0))
                r_post_cnt <= r_post_cnt - 1'b1;

            if (w_edge) begin
                r_h_cnt     <= '0;
                line_cnt    <= '0;
                line_type   <= LT_BROAD;
                frame_lines <= w_frame_meas;
                r_lock_cnt  <= w_lock_nxt;
                locked      <= (w_lock_nxt == LK_W'(LOCK_FRAMES));
            end else if (w_wrap) begin
                r_h_cnt   <= '0;
                line_cnt  <= w_line_nxt;
                line_type <= w_vs_act ? LT_BROAD : (w_eq_win ? LT_EQ : LT_NORMAL);
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_csync_adaptive.sv
// Bench for csync_adaptive with shortened line/frame timing; reference model works from absolute cycle arithmetic.
// Build with CSYNC_EQ_PULSES_EN defined or not; expectations follow the same macro.
module tb_csync_adaptive;

    localparam int L     = 100;
    localparam int HS    = 8;
    localparam int SE    = 6;
    localparam int EQ    = 4;
    localparam int EQL   = 3;
    localparam int TOL   = 4;
    localparam int LF    = 3;
    localparam int HALF  = L / 2;
    localparam int LMAX  = 511;
    localparam int FR    = 20;
    localparam int SHIFT = 25;
`ifdef CSYNC_EQ_PULSES_EN
    localparam bit EQ_EN = 1'b1;
`else
    localparam bit EQ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vsync = 1'b1;
    logic       csync, hsync, locked;
    logic [1:0] line_type;
    logic [8:0] line_cnt, frame_lines;
    logic [22:0] w_got;

    int n_chk = 0;
    int n_fail = 0;

    // reference model state
    longint cyc = 0;
    longint ca = 0;
    bit     m_vsq = 0;
    int     m_lock = 0;
    bit     m_locked = 0;
    int     m_frame = 0;
    int     m_type = 0;
    int     m_post = 0;
    bit     e_cs = 1;
    bit     e_hs = 1;

    csync_adaptive #(
        .LINE_CLKS(L), .HSYNC_CLKS(HS), .SERR_CLKS(SE), .EQ_CLKS(EQ), .EQ_LINES(EQL),
        .LINE_W(9), .LOCK_TOL(TOL), .LOCK_FRAMES(LF), .VSYNC_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .csync(csync), .hsync(hsync),
        .line_type(line_type), .line_cnt(line_cnt), .frame_lines(frame_lines), .locked(locked)
    );

    always #5 clk = ~clk;

    assign w_got = {csync, hsync, line_type, line_cnt, frame_lines, locked};

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [22:0] exp_vec();
        int el;
        int ty;
        int fr;
        el = imin(int'((cyc - ca) / L), LMAX);
        ty = m_type;
        fr = m_frame;
        return {e_cs, e_hs, ty[1:0], el[8:0], fr[8:0], m_locked};
    endfunction

    // One clock: advance model with the inputs seen at this edge, then settle.
    task automatic tick();
        longint n;
        int h, ln, nl;
        bit vs, low;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            ca = cyc; m_vsq = 0; m_lock = 0; m_locked = 0; m_frame = 0;
            m_type = 0; m_post = 0; e_cs = 1; e_hs = 1;
        end else begin
            n  = cyc - ca - 1;
            h  = int'(n % L);
            ln = imin(int'(n / L), LMAX);
            vs = (vsync == 1'b0);
            if (m_type == 1)      low = !((h >= HALF - SE && h < HALF) || h >= L - SE);
            else if (m_type == 2) low = (h < EQ) || (h >= HALF && h < HALF + EQ);
            else                  low = (h < HS);
            e_cs = !low;
            e_hs = !(h < HS);
            if (vs && !m_vsq) begin
                m_frame = imin(ln + ((h >= HALF) ? 1 : 0), LMAX);
                if (h <= TOL || h >= L - TOL) m_lock = imin(m_lock + 1, LF);
                else m_lock = 0;
                m_locked = (m_lock == LF);
                ca = cyc;
                m_type = 1;
            end else if (h == L - 1) begin
                nl = imin(ln + 1, LMAX);
                if (vs) m_type = 1;
                else if (EQ_EN && ((m_locked && nl + EQL >= m_frame) || m_post > 0)) m_type = 2;
                else m_type = 0;
                if (!vs && m_post > 0) m_post--;
            end
            if (vs) m_post = EQL;
            m_vsq = vs;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        vsync = 1'b1;
        repeat (4) tick();
        n_chk++; if (csync !== 1'b1) begin n_fail++; $display("FAIL reset_csync got=%b want=1", csync); end
        n_chk++; if (hsync !== 1'b1) begin n_fail++; $display("FAIL reset_hsync got=%b want=1", hsync); end
        n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got=%b want=0", locked); end
        n_chk++; if (line_cnt !== 9'd0) begin n_fail++; $display("FAIL reset_line_cnt got=%0d want=0", line_cnt); end
        n_chk++; if (frame_lines !== 9'd0) begin n_fail++; $display("FAIL reset_frame_lines got=%0d want=0", frame_lines); end
        n_chk++; if (line_type !== 2'd0) begin n_fail++; $display("FAIL reset_line_type got=%0d want=0", line_type); end
    endtask

    task automatic test_free_run();
        int lows;
        lows = 0;
        rst_n = 1'b1;
        vsync = 1'b1;
        for (int k = 0; k < 5 * L; k++) begin
            tick();
            if (csync === 1'b0) lows++;
            if (n_fail < 30) begin
                n_chk++;
                if (w_got !== exp_vec()) begin n_fail++; $display("FAIL free_run_stream cyc=%0d got=%h want=%h", cyc, w_got, exp_vec()); end
            end
        end
        n_chk++; if (lows != 5 * HS) begin n_fail++; $display("FAIL free_run_low_clks got=%0d want=%0d", lows, 5 * HS); end
        n_chk++; if (line_cnt !== 9'd5) begin n_fail++; $display("FAIL free_run_line_cnt got=%0d want=5", line_cnt); end
    endtask

    task automatic test_broad_lines();
        int off, highs;
        highs = 0;
        off = int'($urandom_range(TOL + 1, L - TOL - 1));
        for (int k = 0; k < off; k++) begin
            vsync = 1'b1;
            tick();
            if (n_fail < 30) begin
                n_chk++;
                if (w_got !== exp_vec()) begin n_fail++; $display("FAIL broad_pre_stream cyc=%0d got=%h want=%h", cyc, w_got, exp_vec()); end
            end
        end
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < FR * L; k++) begin
                vsync = (k < 3 * L) ? 1'b0 : 1'b1;
                tick();
                if (n_fail < 30) begin
                    n_chk++;
                    if (w_got !== exp_vec()) begin n_fail++; $display("FAIL broad_stream cyc=%0d got=%h want=%h", cyc, w_got, exp_vec()); end
                end
                if (f == 0 && k >= L + 1 && k <= 2 * L && csync === 1'b1) highs++;
                if (f == 0 && k == 0) begin
                    n_chk++; if (line_type !== 2'd1) begin n_fail++; $display("FAIL broad_type_on_edge got=%0d want=1", line_type); end
                end
                if (f == 1 && k == 0) begin
                    n_chk++; if (frame_lines !== 9'(FR)) begin n_fail++; $display("FAIL broad_frame_lines got=%0d want=%0d", frame_lines, FR); end
                end
            end
        end
        n_chk++; if (highs != 2 * SE) begin n_fail++; $display("FAIL broad_serration_clks got=%0d want=%0d", highs, 2 * SE); end
    endtask

    task automatic test_lock();
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < FR * L; k++) begin
                vsync = (k < 3 * L) ? 1'b0 : 1'b1;
                tick();
                if (n_fail < 30) begin
                    n_chk++;
                    if (w_got !== exp_vec()) begin n_fail++; $display("FAIL lock_stream cyc=%0d got=%h want=%h", cyc, w_got, exp_vec()); end
                end
                if (k == 0) begin
                    n_chk++;
                    if (locked !== (f >= 1)) begin n_fail++; $display("FAIL lock_after_edge frame=%0d got=%b want=%b", f, locked, (f >= 1)); end
                end
            end
        end
    endtask

    task automatic test_eq_lines();
        logic [1:0] eqt;
        eqt = EQ_EN ? 2'd2 : 2'd0;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < FR * L; k++) begin
                vsync = (k < 3 * L) ? 1'b0 : 1'b1;
                tick();
                if (n_fail < 30) begin
                    n_chk++;
                    if (w_got !== exp_vec()) begin n_fail++; $display("FAIL eq_stream cyc=%0d got=%h want=%h", cyc, w_got, exp_vec()); end
                end
                if (k % L == HALF + 1) begin
                    if (k / L == 1) begin
                        n_chk++; if (line_type !== 2'd1 || csync !== 1'b0) begin n_fail++; $display("FAIL eq_broad_mid type=%0d csync=%b want type=1 csync=0", line_type, csync); end
                    end
                    if (k / L == 3 || k / L == 5 || k / L == FR - 3 || k / L == FR - 1) begin
                        n_chk++;
                        if (line_type !== eqt || csync !== !EQ_EN) begin
                            n_fail++; $display("FAIL eq_line_mid line=%0d type=%0d csync=%b want type=%0d csync=%b", k / L, line_type, csync, eqt, !EQ_EN);
                        end
                    end
                    if (k / L == 6 || k / L == FR - 4) begin
                        n_chk++; if (line_type !== 2'd0 || csync !== 1'b1) begin n_fail++; $display("FAIL eq_normal_mid line=%0d type=%0d csync=%b want type=0 csync=1", k / L, line_type, csync); end
                    end
                end
            end
        end
    endtask

    task automatic test_phase_shift();
        for (int k = 0; k < FR * L + SHIFT; k++) begin
            vsync = (k < 3 * L) ? 1'b0 : 1'b1;
            tick();
            if (n_fail < 30) begin
                n_chk++;
                if (w_got !== exp_vec()) begin n_fail++; $display("FAIL shift_stream cyc=%0d got=%h want=%h", cyc, w_got, exp_vec()); end
            end
            if (k == 0) begin
                n_chk++; if (locked !== 1'b1) begin n_fail++; $display("FAIL shift_still_locked got=%b want=1", locked); end
            end
        end
        vsync = 1'b0;
        tick();
        n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL shift_unlock got=%b want=0", locked); end
        n_chk++; if (frame_lines !== 9'(FR)) begin n_fail++; $display("FAIL shift_frame_lines got=%0d want=%0d", frame_lines, FR); end
    endtask

    task automatic test_reset_mid_vsync();
        for (int k = 0; k < L + 10; k++) begin
            vsync = 1'b0;
            tick();
            if (n_fail < 30) begin
                n_chk++;
                if (w_got !== exp_vec()) begin n_fail++; $display("FAIL rstmid_pre_stream cyc=%0d got=%h want=%h", cyc, w_got, exp_vec()); end
            end
        end
        rst_n = 1'b0;
        tick();
        n_chk++;
        if ({csync, hsync, locked, line_cnt, frame_lines, line_type} !== {1'b1, 1'b1, 1'b0, 9'd0, 9'd0, 2'd0}) begin
            n_fail++; $display("FAIL rstmid_outputs got cs=%b hs=%b lk=%b ln=%0d fr=%0d ty=%0d want 1 1 0 0 0 0", csync, hsync, locked, line_cnt, frame_lines, line_type);
        end
        rst_n = 1'b1;
        for (int e = 0; e < 4; e++) begin
            for (int k = 0; k < FR * L; k++) begin
                vsync = (k < 3 * L) ? 1'b0 : 1'b1;
                tick();
                if (n_fail < 30) begin
                    n_chk++;
                    if (w_got !== exp_vec()) begin n_fail++; $display("FAIL rstmid_stream cyc=%0d got=%h want=%h", cyc, w_got, exp_vec()); end
                end
                if (k == 0) begin
                    n_chk++; if (locked !== (e >= 2)) begin n_fail++; $display("FAIL rstmid_relock edge=%0d got=%b want=%b", e, locked, (e >= 2)); end
                end
                if (k == 0 && e >= 1) begin
                    n_chk++; if (frame_lines !== 9'(FR)) begin n_fail++; $display("FAIL rstmid_frame_lines got=%0d want=%0d", frame_lines, FR); end
                end
            end
        end
    endtask

    task automatic test_random_frames();
        int act, len;
        for (int f = 0; f < 6; f++) begin
            act = int'($urandom_range(L / 2, 4 * L));
            len = int'($urandom_range(8 * L, 25 * L));
            for (int k = 0; k < len; k++) begin
                vsync = (k < act) ? 1'b0 : 1'b1;
                tick();
                if (n_fail < 30) begin
                    n_chk++;
                    if (w_got !== exp_vec()) begin n_fail++; $display("FAIL random_stream cyc=%0d got=%h want=%h", cyc, w_got, exp_vec()); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_broad_lines();
        test_lock();
        test_eq_lines();
        test_phase_shift();
        test_reset_mid_vsync();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
